// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the three writeback requesters / decode and the
// register-file write-port arbiter. The master side is the pipeline, and the
// slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    // ALU writeback request
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;

    // Load writeback request
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;

    // Link writeback request (destination is always the last register)
    logic          lnk_valid;
    logic [DW-1:0] lnk_data;
    logic          lnk_ready;

    // Decode-side scoreboard access
    logic          iss_valid;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] chk_addr_1;
    logic [AW-1:0] chk_addr_2;
    logic          chk_busy;

    // Register-file write command
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        output lnk_valid, lnk_data,
        input  lnk_ready,
        output iss_valid, iss_addr, chk_addr_1, chk_addr_2,
        input  chk_busy,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        input  lnk_valid, lnk_data,
        output lnk_ready,
        input  iss_valid, iss_addr, chk_addr_1, chk_addr_2,
        output chk_busy,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among the
// ALU, load and link writeback requesters. The write command is registered.
// A pending-write scoreboard lets decode stall on in-flight destinations.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int NREG = 1 << AW;

    // Requester currently holding top priority
    typedef enum logic [1:0] {
        PTR_ALU = 2'd0,
        PTR_LD  = 2'd1,
        PTR_LNK = 2'd2
    } ptr_e;

    ptr_e              ptr_r;
    ptr_e              ptr_nxt_s;
    logic [NREQ-1:0]   valid_s;
    logic [NREQ-1:0]   gnt_s;
    logic              gnt_any_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_data_s;
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   set_mask_s;
    logic [NREG-1:0]   clr_mask_s;
    logic [NREG-1:0]   busy_nxt_s;
    logic              rf_we_r;
    logic [AW-1:0]     rf_waddr_r;
    logic [DW-1:0]     rf_wdata_r;

    assign valid_s   = {bus.lnk_valid, bus.ld_valid, bus.alu_valid};
    assign gnt_any_s = |gnt_s;

    // Readies are forced low while reset is held so nothing is consumed then
    assign bus.alu_ready = gnt_s[0] & rst_n;
    assign bus.ld_ready  = gnt_s[1] & rst_n;
    assign bus.lnk_ready = gnt_s[2] & rst_n;

    assign bus.rf_we    = rf_we_r;
    assign bus.rf_waddr = rf_waddr_r;
    assign bus.rf_wdata = rf_wdata_r;

    // Launched writes are already gone from busy_r, so they never stall decode
    assign bus.chk_busy = busy_r[bus.chk_addr_1] | busy_r[bus.chk_addr_2];

    // Grant the first valid requester searching from the pointer, wrapping mod 3
    always_comb begin
        gnt_s = 3'b000;
        case (ptr_r)
            PTR_ALU: begin
                if (valid_s[0])      gnt_s = 3'b001;
                else if (valid_s[1]) gnt_s = 3'b010;
                else if (valid_s[2]) gnt_s = 3'b100;
                else                 gnt_s = 3'b000;
            end
            PTR_LD: begin
                if (valid_s[1])      gnt_s = 3'b010;
                else if (valid_s[2]) gnt_s = 3'b100;
                else if (valid_s[0]) gnt_s = 3'b001;
                else                 gnt_s = 3'b000;
            end
            PTR_LNK: begin
                if (valid_s[2])      gnt_s = 3'b100;
                else if (valid_s[0]) gnt_s = 3'b001;
                else if (valid_s[1]) gnt_s = 3'b010;
                else                 gnt_s = 3'b000;
            end
            default: gnt_s = 3'b000;
        endcase
    end

    // Move priority to the requester just after the winner; hold when idle
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (gnt_s[0])      ptr_nxt_s = PTR_LD;
        else if (gnt_s[1]) ptr_nxt_s = PTR_LNK;
        else if (gnt_s[2]) ptr_nxt_s = PTR_ALU;
        else               ptr_nxt_s = ptr_r;
    end

    // Select the destination and data of the granted requester
    always_comb begin
        sel_addr_s = {AW{1'b0}};
        sel_data_s = {DW{1'b0}};
        case (gnt_s)
            3'b001: begin
                sel_addr_s = bus.alu_addr;
                sel_data_s = bus.alu_data;
            end
            3'b010: begin
                sel_addr_s = bus.ld_addr;
                sel_data_s = bus.ld_data;
            end
            3'b100: begin
                sel_addr_s = {AW{1'b1}};
                sel_data_s = bus.lnk_data;
            end
            default: begin
                sel_addr_s = {AW{1'b0}};
                sel_data_s = {DW{1'b0}};
            end
        endcase
    end

    // Scoreboard update: clear the accepted destination, then apply the new issue
    always_comb begin
        set_mask_s = {NREG{1'b0}};
        clr_mask_s = {NREG{1'b0}};
        if (bus.iss_valid) begin
            set_mask_s = {{(NREG-1){1'b0}}, 1'b1} << bus.iss_addr;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        if (gnt_any_s) begin
            clr_mask_s = {{(NREG-1){1'b0}}, 1'b1} << sel_addr_s;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        // Set is applied last, so a newer producer wins over a same-edge clear
        busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~{{(NREG-1){1'b0}}, 1'b1};
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= PTR_ALU;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    // Registered write command; register 0 is consumed but never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {AW{1'b0}};
            rf_wdata_r <= {DW{1'b0}};
        end else if (gnt_any_s && (sel_addr_s != {AW{1'b0}})) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= sel_addr_s;
            rf_wdata_r <= sel_data_s;
        end else begin
            rf_we_r    <= 1'b0;
        end
    end

    // Pending-write scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a directed vector table with hand-derived
// expectations, reset sequences, and randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

    regfile_wb_arbiter #(.NREQ(3), .DW(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_ptr;
    bit [31:0]   m_busy;
    bit          m_we;
    bit [4:0]    m_waddr;
    bit [31:0]   m_wdata;
    logic [2:0]  act_rdy;

    typedef struct {
        bit        alu_v; bit [4:0] alu_a; bit [31:0] alu_d;
        bit        ld_v;  bit [4:0] ld_a;  bit [31:0] ld_d;
        bit        lnk_v; bit [31:0] lnk_d;
        bit        iss_v; bit [4:0] iss_a;
        bit [4:0]  c1;    bit [4:0] c2;
        bit [2:0]  rdy;   bit we; bit [4:0] wa; bit [31:0] wd; bit busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit alu_v, bit [4:0] alu_a, bit [31:0] alu_d,
                                bit ld_v, bit [4:0] ld_a, bit [31:0] ld_d,
                                bit lnk_v, bit [31:0] lnk_d,
                                bit iss_v, bit [4:0] iss_a, bit [4:0] c1, bit [4:0] c2,
                                bit [2:0] rdy, bit we, bit [4:0] wa, bit [31:0] wd, bit busy);
        vec_t v;
        v.alu_v = alu_v; v.alu_a = alu_a; v.alu_d = alu_d;
        v.ld_v = ld_v; v.ld_a = ld_a; v.ld_d = ld_d;
        v.lnk_v = lnk_v; v.lnk_d = lnk_d;
        v.iss_v = iss_v; v.iss_a = iss_a; v.c1 = c1; v.c2 = c2;
        v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit alu_v, input bit [4:0] alu_a, input bit [31:0] alu_d,
                         input bit ld_v, input bit [4:0] ld_a, input bit [31:0] ld_d,
                         input bit lnk_v, input bit [31:0] lnk_d,
                         input bit iss_v, input bit [4:0] iss_a, input bit [4:0] c1, input bit [4:0] c2);
        bus.alu_valid = alu_v; bus.alu_addr = alu_a; bus.alu_data = alu_d;
        bus.ld_valid = ld_v;   bus.ld_addr = ld_a;   bus.ld_data = ld_d;
        bus.lnk_valid = lnk_v; bus.lnk_data = lnk_d;
        bus.iss_valid = iss_v; bus.iss_addr = iss_a;
        bus.chk_addr_1 = c1;   bus.chk_addr_2 = c2;
    endtask

    task automatic drive_idle(input bit [4:0] c1, input bit [4:0] c2);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, c1, c2);
    endtask

    // First valid requester found scanning from the priority pointer, -1 if none
    function automatic int model_grant(int ptr, bit [2:0] v);
        for (int k = 0; k < 3; k++) begin
            int j;
            j = (ptr + k) % 3;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_busy = 32'd0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    endfunction

    // One clock cycle: inputs already driven just after the previous edge
    task automatic run_cycle();
        int        g;
        bit [2:0]  v;
        bit [2:0]  exp_rdy;
        bit [4:0]  a;
        bit [31:0] d;
        bit        iv;
        bit [4:0]  ia;
        #2;
        v  = {bus.lnk_valid, bus.ld_valid, bus.alu_valid};
        g  = model_grant(m_ptr, v);
        exp_rdy = (g < 0) ? 3'b000 : (3'b001 << g);
        act_rdy = {bus.lnk_ready, bus.ld_ready, bus.alu_ready};
        check("ready", {29'd0, act_rdy}, {29'd0, exp_rdy});
        a  = (g == 0) ? bus.alu_addr : (g == 1) ? bus.ld_addr : 5'd31;
        d  = (g == 0) ? bus.alu_data : (g == 1) ? bus.ld_data : bus.lnk_data;
        iv = bus.iss_valid;
        ia = bus.iss_addr;
        @(posedge clk);
        m_we = 1'b0;
        if (g >= 0) begin
            m_ptr = (g + 1) % 3;
            if (a != 5'd0) begin
                m_we = 1'b1; m_waddr = a; m_wdata = d;
            end
            m_busy[a] = 1'b0;
        end
        if (iv && ia != 5'd0) m_busy[ia] = 1'b1;
        #1;
        check("rf_we", {31'd0, bus.rf_we}, {31'd0, m_we});
        check("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, m_waddr});
        check("rf_wdata", bus.rf_wdata, m_wdata);
        check("chk_busy", {31'd0, bus.chk_busy},
              {31'd0, m_busy[bus.chk_addr_1] | m_busy[bus.chk_addr_2]});
    endtask

    // Assert reset mid-cycle with traffic present, then release it
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1, 32'h3, 1'b1, 5'd7, 5'd7, 5'd9);
        #1;
        check("rst_ready", {29'd0, bus.lnk_ready, bus.ld_ready, bus.alu_ready}, 32'd0);
        check("rst_we", {31'd0, bus.rf_we}, 32'd0);
        check("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        check("rst_wdata", bus.rf_wdata, 32'd0);
        check("rst_busy", {31'd0, bus.chk_busy}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_we_hold", {31'd0, bus.rf_we}, 32'd0);
        check("rst_ready_hold", {29'd0, bus.lnk_ready, bus.ld_ready, bus.alu_ready}, 32'd0);
        drive_idle(5'd7, 5'd9);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("post_rst_we", {31'd0, bus.rf_we}, 32'd0);
        check("post_rst_busy", {31'd0, bus.chk_busy}, 32'd0);
    endtask

    initial begin
        bit        pend[3];
        bit [4:0]  raddr[3];
        bit [31:0] rdata[3];

        drive_idle(5'd0, 5'd0);
        model_reset();
        do_reset();

        // Round-robin, single write, register-zero drop, scoreboard corners
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(1, 5'd3, 32'h11111111, 1, 5'd4, 32'h22222222, 1, 32'h00400010, 0, 5'd0, 5'd0, 5'd0, 3'b001, 1, 5'd3,  32'h11111111, 0));
            tbl.push_back(mk(1, 5'd3, 32'h11111111, 1, 5'd4, 32'h22222222, 1, 32'h00400010, 0, 5'd0, 5'd0, 5'd0, 3'b010, 1, 5'd4,  32'h22222222, 0));
            tbl.push_back(mk(1, 5'd3, 32'h11111111, 1, 5'd4, 32'h22222222, 1, 32'h00400010, 0, 5'd0, 5'd0, 5'd0, 3'b100, 1, 5'd31, 32'h00400010, 0));
        end
        tbl.push_back(mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd0, 5'd0,  3'b001, 1, 5'd5,  32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd0, 5'd0,  3'b000, 0, 5'd5,  32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h12345678, 0, 32'h0,        0, 5'd0,  5'd0, 5'd0,  3'b010, 0, 5'd5,  32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 32'h0,        1, 5'd7,  5'd7, 5'd0,  3'b000, 0, 5'd5,  32'hDEADBEEF, 1));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd7, 5'd0,  3'b000, 0, 5'd5,  32'hDEADBEEF, 1));
        tbl.push_back(mk(1, 5'd7,  32'hA5A5A5A5, 0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd7, 5'd0,  3'b001, 1, 5'd7,  32'hA5A5A5A5, 0));
        tbl.push_back(mk(1, 5'd7,  32'h5A5A5A5A, 0, 5'd0,  32'h0,        0, 32'h0,        1, 5'd7,  5'd7, 5'd0,  3'b001, 1, 5'd7,  32'h5A5A5A5A, 1));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd7, 5'd0,  3'b000, 0, 5'd7,  32'h5A5A5A5A, 1));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h00001000, 0, 5'd0,  5'd7, 5'd0,  3'b100, 1, 5'd31, 32'h00001000, 1));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 32'h0,        1, 5'd12, 5'd0, 5'd12, 3'b000, 0, 5'd31, 32'h00001000, 1));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 32'h0,        1, 5'd0,  5'd0, 5'd0,  3'b000, 0, 5'd31, 32'h00001000, 0));
        tbl.push_back(mk(1, 5'd7,  32'h0BADF00D, 1, 5'd12, 32'hCAFEF00D, 0, 32'h0,        0, 5'd0,  5'd7, 5'd12, 3'b001, 1, 5'd7,  32'h0BADF00D, 1));
        tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd12, 32'hCAFEF00D, 0, 32'h0,        0, 5'd0,  5'd7, 5'd12, 3'b010, 1, 5'd12, 32'hCAFEF00D, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].alu_v, tbl[i].alu_a, tbl[i].alu_d, tbl[i].ld_v, tbl[i].ld_a, tbl[i].ld_d,
                  tbl[i].lnk_v, tbl[i].lnk_d, tbl[i].iss_v, tbl[i].iss_a, tbl[i].c1, tbl[i].c2);
            run_cycle();
            check($sformatf("tbl%0d_rdy", i), {29'd0, act_rdy}, {29'd0, tbl[i].rdy});
            check($sformatf("tbl%0d_we", i), {31'd0, bus.rf_we}, {31'd0, tbl[i].we});
            check($sformatf("tbl%0d_waddr", i), {27'd0, bus.rf_waddr}, {27'd0, tbl[i].wa});
            check($sformatf("tbl%0d_wdata", i), bus.rf_wdata, tbl[i].wd);
            check($sformatf("tbl%0d_busy", i), {31'd0, bus.chk_busy}, {31'd0, tbl[i].busy});
        end

        // Reset mid-operation: issue to 9 and a load to 9 are both discarded
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99999999, 1'b0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        #2;
        check("midrst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {29'd0, bus.lnk_ready, bus.ld_ready, bus.alu_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_we", {31'd0, bus.rf_we}, 32'd0);
        check("midrst_busy", {31'd0, bus.chk_busy}, 32'd0);
        drive_idle(5'd9, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("midrst_we_after", {31'd0, bus.rf_we}, 32'd0);
        check("midrst_busy9_after", {31'd0, bus.chk_busy}, 32'd0);

        // Randomized traffic with requesters holding requests until accepted
        for (int r = 0; r < 3; r++) pend[r] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 3; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r]  = 1'b1;
                    raddr[r] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    rdata[r] = $urandom;
                end
            end
            drive(pend[0], raddr[0], rdata[0], pend[1], raddr[1], rdata[1], pend[2], rdata[2],
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            run_cycle();
            for (int r = 0; r < 3; r++) begin
                if (act_rdy[r] === 1'b1) pend[r] = 1'b0;
            end
        end

        drive_idle(5'd0, 5'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
